// File: rtl/serializer_parallel_pkg.sv
// Shared types for the parallel-to-serial converter.
// State encoding and counter width helper.
package serializer_parallel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serializer_parallel_control.sv
// Control FSM for the parallel-to-serial converter.
// Tracks element index and generates both handshakes.
module serializer_parallel_control
  import serializer_parallel_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  localparam int CNT_W = cnt_w(N_SAMPLES)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             recv_val,
  input  logic             send_rdy,
  output logic             recv_rdy,
  output logic             send_val,
  output logic             load_en,
  output logic [CNT_W-1:0] count
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  assign last  = (cnt_q == CNT_W'(N_SAMPLES - 1));
  assign count = cnt_q;

  // State and element counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter advance and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    load_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        load_en  = recv_val;
        if (recv_val) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        send_val = 1'b1;
        recv_rdy = last & send_rdy;
        if (send_rdy) begin
          if (last) begin
            cnt_d   = '0;
            load_en = recv_val;
            state_d = recv_val ? SEND : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serializer_parallel.sv
// Parallel-to-serial converter, element 0 first.
// Holding register plus element select mux.
module serializer_parallel
  import serializer_parallel_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  localparam int CNT_W = cnt_w(N_SAMPLES)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  logic [N_SAMPLES*BIT_WIDTH-1:0] data_q;
  logic                           load_en;
  logic [CNT_W-1:0]               count;

  serializer_parallel_control #(
    .N_SAMPLES(N_SAMPLES)
  ) u_ctrl (
    .CLK     (CLK),
    .RESET   (RESET),
    .recv_val(recv_val),
    .send_rdy(send_rdy),
    .recv_rdy(recv_rdy),
    .send_val(send_val),
    .load_en (load_en),
    .count   (count)
  );

  // Capture a whole word when the receive side fires.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q <= '0;
    end else if (load_en) begin
      data_q <= recv_msg;
    end
  end

  // Select current element; zero while idle.
  always_comb begin
    send_msg = '0;
    if (send_val) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        if (count == CNT_W'(k)) begin
          send_msg = data_q[k*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_serializer_parallel.sv
// Bench for serializer_parallel: W=8/N=4 and W=16/N=1.
// Queue model of pending elements predicts all outputs.
module tb_serializer_parallel;

  logic        CLK;
  logic        RESET;

  logic [31:0] a_recv_msg;
  logic        a_recv_val;
  logic        a_recv_rdy;
  logic [7:0]  a_send_msg;
  logic        a_send_val;
  logic        a_send_rdy;

  logic [15:0] b_recv_msg;
  logic        b_recv_val;
  logic        b_recv_rdy;
  logic [15:0] b_send_msg;
  logic        b_send_val;
  logic        b_send_rdy;

  int total;
  int bad;

  logic [7:0]  qa[$];
  logic [15:0] qb[$];

  serializer_parallel #(
    .BIT_WIDTH(8),
    .N_SAMPLES(4)
  ) dut_a (
    .CLK     (CLK),
    .RESET   (RESET),
    .recv_msg(a_recv_msg),
    .recv_val(a_recv_val),
    .recv_rdy(a_recv_rdy),
    .send_msg(a_send_msg),
    .send_val(a_send_val),
    .send_rdy(a_send_rdy)
  );

  serializer_parallel #(
    .BIT_WIDTH(16),
    .N_SAMPLES(1)
  ) dut_b (
    .CLK     (CLK),
    .RESET   (RESET),
    .recv_msg(b_recv_msg),
    .recv_val(b_recv_val),
    .recv_rdy(b_recv_rdy),
    .send_msg(b_send_msg),
    .send_val(b_send_val),
    .send_rdy(b_send_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic a_exp_val();
    return qa.size() != 0;
  endfunction

  function automatic logic [7:0] a_exp_msg();
    return (qa.size() != 0) ? qa[0] : 8'h00;
  endfunction

  function automatic logic a_exp_rdy();
    return (qa.size() == 0) || (qa.size() == 1 && a_send_rdy);
  endfunction

  function automatic logic b_exp_val();
    return qb.size() != 0;
  endfunction

  function automatic logic [15:0] b_exp_msg();
    return (qb.size() != 0) ? qb[0] : 16'h0000;
  endfunction

  function automatic logic b_exp_rdy();
    return (qb.size() == 0) || (qb.size() == 1 && b_send_rdy);
  endfunction

  task automatic check_all();
    check("a_val", 32'(a_send_val), 32'(a_exp_val()));
    check("a_msg", 32'(a_send_msg), 32'(a_exp_msg()));
    check("a_rdy", 32'(a_recv_rdy), 32'(a_exp_rdy()));
    check("b_val", 32'(b_send_val), 32'(b_exp_val()));
    check("b_msg", 32'(b_send_msg), 32'(b_exp_msg()));
    check("b_rdy", 32'(b_recv_rdy), 32'(b_exp_rdy()));
  endtask

  task automatic model_step();
    logic a_acc_r, a_acc_s, b_acc_r, b_acc_s;
    a_acc_r = a_recv_val && a_exp_rdy();
    a_acc_s = a_exp_val() && a_send_rdy;
    b_acc_r = b_recv_val && b_exp_rdy();
    b_acc_s = b_exp_val() && b_send_rdy;
    if (a_acc_s) void'(qa.pop_front());
    if (a_acc_r)
      for (int k = 0; k < 4; k++) qa.push_back(a_recv_msg[k*8 +: 8]);
    if (b_acc_s) void'(qb.pop_front());
    if (b_acc_r) qb.push_back(b_recv_msg);
  endtask

  task automatic cyc();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1;
    a_recv_msg = '0; a_recv_val = 1'b0; a_send_rdy = 1'b1;
    b_recv_msg = '0; b_recv_val = 1'b0; b_send_rdy = 1'b1;
    #3;
    check("rst_a_val", 32'(a_send_val), 32'd0);
    check("rst_a_msg", 32'(a_send_msg), 32'd0);
    check("rst_a_rdy", 32'(a_recv_rdy), 32'd1);
    check("rst_b_val", 32'(b_send_val), 32'd0);
    check("rst_b_rdy", 32'(b_recv_rdy), 32'd1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Basic serialization
    a_recv_msg = 32'hDDCCBBAA; a_recv_val = 1'b1;
    cyc();
    a_recv_val = 1'b0; a_recv_msg = '0;
    @(negedge CLK);
    check("basic_first", 32'(a_send_msg), 32'h000000AA);
    @(posedge CLK); model_step(); #1;
    repeat (5) cyc();
    check("basic_idle_rdy", 32'(a_recv_rdy), 32'd1);

    // Backpressure after BB appears
    a_recv_msg = 32'hDDCCBBAA; a_recv_val = 1'b1;
    cyc();
    a_recv_val = 1'b0;
    cyc();
    a_send_rdy = 1'b0;
    repeat (3) begin
      cyc();
      check("bp_hold", 32'(a_send_msg), 32'h000000BB);
    end
    a_send_rdy = 1'b1;
    repeat (4) cyc();

    // Back-to-back words with recv_val held
    a_recv_msg = 32'h04030201; a_recv_val = 1'b1;
    cyc();
    a_recv_msg = 32'h08070605;
    repeat (3) cyc();
    check("b2b_rdy", 32'(a_recv_rdy), 32'd1);
    cyc();
    a_recv_val = 1'b0;
    repeat (5) cyc();

    // Input ignored while sending
    a_recv_msg = 32'hDDCCBBAA; a_recv_val = 1'b1;
    cyc();
    a_recv_val = 1'b0;
    cyc();
    a_recv_msg = 32'hFFFFFFFF; a_recv_val = 1'b1;
    @(negedge CLK);
    check("ign_rdy", 32'(a_recv_rdy), 32'd0);
    @(posedge CLK); model_step(); #1;
    a_recv_val = 1'b0;
    repeat (4) cyc();

    // Async reset mid-word
    a_recv_msg = 32'hDDCCBBAA; a_recv_val = 1'b1;
    cyc();
    a_recv_val = 1'b0;
    repeat (2) cyc();
    RESET = 1'b1;
    #1;
    check("rst_mid_val", 32'(a_send_val), 32'd0);
    check("rst_mid_rdy", 32'(a_recv_rdy), 32'd1);
    qa.delete();
    qb.delete();
    #1;
    RESET = 1'b0;
    a_recv_msg = 32'h44332211; a_recv_val = 1'b1;
    cyc();
    a_recv_val = 1'b0;
    @(negedge CLK);
    check("rst_next", 32'(a_send_msg), 32'h00000011);
    @(posedge CLK); model_step(); #1;
    repeat (4) cyc();

    // N=1 back-to-back and full backpressure
    b_recv_msg = 16'hBEEF; b_recv_val = 1'b1;
    cyc();
    b_recv_msg = 16'hCAFE;
    @(negedge CLK);
    check("n1_beef", 32'(b_send_msg), 32'h0000BEEF);
    @(posedge CLK); model_step(); #1;
    b_recv_val = 1'b0;
    @(negedge CLK);
    check("n1_cafe", 32'(b_send_msg), 32'h0000CAFE);
    @(posedge CLK); model_step(); #1;
    cyc();
    b_send_rdy = 1'b0;
    b_recv_msg = 16'h1234; b_recv_val = 1'b1;
    cyc();
    b_recv_msg = 16'h5678;
    @(negedge CLK);
    check("n1_full_rdy", 32'(b_recv_rdy), 32'd0);
    @(posedge CLK); model_step(); #1;
    repeat (2) cyc();
    b_send_rdy = 1'b1;
    repeat (3) cyc();
    b_recv_val = 1'b0;
    repeat (2) cyc();

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_recv_msg = $urandom;
      a_recv_val = ($urandom_range(0, 3) != 0);
      a_send_rdy = ($urandom_range(0, 3) != 0);
      b_recv_msg = 16'($urandom);
      b_recv_val = ($urandom_range(0, 2) != 0);
      b_send_rdy = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serializer_parallel.md
Name: serializer_parallel

Overview:
- Parallel-to-serial converter with val/rdy on both sides.
- Accepts one wide word of N_SAMPLES elements on the receive interface, then emits the elements one per send handshake, element 0 first.
- Opposite direction of the team's serial-to-parallel collector. It sits between wide-word producers (e.g. FFT output) and narrow serial consumers.
- Datapath is a holding register plus an element-select mux. Control is a 2-state FSM with an element counter.

Parameters:
- BIT_WIDTH, 32, width of one element in bits.
- N_SAMPLES, 8, elements per parallel word; legal range >= 1.
- CNT_W, $clog2(N_SAMPLES) (minimum 1), counter/select width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- recv_msg  input  N_SAMPLES*BIT_WIDTH  parallel word; element k = recv_msg[k*BIT_WIDTH +: BIT_WIDTH].
- recv_val  input  1  recv_msg valid.
- recv_rdy  output  1  block can accept a parallel word.
- send_msg  output  BIT_WIDTH  current serial element.
- send_val  output  1  send_msg valid.
- send_rdy  input  1  consumer accepts send_msg.

Behaviour:
- Reset (async assert, sampled deassert on CLK):
  - state=IDLE, count=0, holding register=0.
  - Outputs: send_val=0, send_msg=0, recv_rdy=1.
- Handshake rule: a transfer occurs on a posedge where val&rdy=1. val must not depend on rdy on either side.
- States:
  - IDLE: recv_rdy=1, send_val=0. On recv_val&recv_rdy: capture recv_msg into register, count<=0, go to SEND.
  - SEND: send_val=1, send_msg=reg element[count].
    - On send_val&send_rdy with count<N_SAMPLES-1: count<=count+1, stay in SEND.
    - On send_val&send_rdy with count==N_SAMPLES-1 (last element): count<=0.
      - If recv_val is also high: capture the new word, stay in SEND (back-to-back, no bubble).
      - Otherwise go to IDLE.
- recv_rdy = (state==IDLE) | (state==SEND & count==N_SAMPLES-1 & send_rdy).
  - This combinational rdy->rdy path is intentional.
  - recv_rdy is 0 in SEND otherwise, so recv_msg changes mid-serialization are ignored.
- Latency: word accepted at edge t; element 0 is valid in the cycle after t. With send_rdy held high, N_SAMPLES elements leave over N_SAMPLES consecutive cycles.
- Throughput: 1 element/cycle sustained under back-to-back input.
- Backpressure: while send_rdy=0 in SEND, send_msg, send_val and count hold stable.
- send_msg is driven to 0 in IDLE, never stale data.
- N_SAMPLES=1: count stays 0. Every send handshake is "last". The block behaves as a 1-entry pipeline register with bubble-free refill.
- Counter never exceeds N_SAMPLES-1 and never wraps past it. Non-power-of-2 N_SAMPLES is supported.
- Reset mid-SEND: partially sent word is discarded, block returns to IDLE immediately (async). The first post-reset element sent is element 0 of the next accepted word.

Decomposition:
- Shared package: state enum {IDLE, SEND} (1-bit encoding).
- One sub-module, serializer_parallel_control:
  - Inputs: recv_val, send_rdy, CLK, RESET.
  - Outputs: recv_rdy, send_val, load_en, count (CNT_W bits).
- Holding register and select mux stay in the top level.

Test Plan:
- Basic, W=8, N=4, send_rdy=1: recv_msg=32'hDDCCBBAA, recv_val for 1 cycle -> send_msg AA, BB, CC, DD on 4 consecutive cycles with send_val=1. Then send_val=0, recv_rdy=1.
- Backpressure: same word, send_rdy=0 for 3 cycles after element BB appears -> BB held stable and count unchanged for those 3 cycles, then CC, DD. No element is lost or duplicated.
- Back-to-back: words 32'h04030201 then 32'h08070605 with recv_val held high -> recv_rdy=1 on the cycle 04 transfers. Output is 01..08 with no send_val gap.
- Ignore input in SEND: change recv_msg to 32'hFFFFFFFF with recv_val=1 while element 1 is sending -> recv_rdy=0, remaining output unaffected.
- Reset mid-operation: assert RESET asynchronously between clock edges after element 1 of 32'hDDCCBBAA -> send_val drops at once, recv_rdy=1. Next word 32'h44332211 outputs 11 first.
- N=1, W=16: words 16'hBEEF, 16'hCAFE back-to-back, send_rdy=1 -> BEEF, CAFE on consecutive cycles. With send_rdy=0, recv_rdy=0 while full.
